// File: rtl/memoria_pkg.sv
// Shared types and constants for the parameterised single-port memory.
package memoria_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  localparam int READ_FIRST  = 0;
  localparam int WRITE_FIRST = 1;

endpackage

// File: rtl/memoria_param.sv
// Single-port word memory with a zeroing sweep after reset; 1-cycle registered read.
// Accepts one request per cycle in IDLE; requests are dropped while busy (CLEAR).
module memoria_param
  import memoria_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 5,
  parameter int DEPTH     = 29,
  parameter int READ_MODE = READ_FIRST
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              en,
  input  logic              S,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] In,
  output logic [DATA_W-1:0] Out,
  output logic              valid,
  output logic              err,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              in_range;
  logic [DATA_W-1:0] rd_word;

  assign in_range = ({1'b0, address} < DEPTH_EXT);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    out_d     = out_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = ptr_q;
    mem_wdata = '0;
    rd_word   = '0;

    case (state_q)
      CLEAR: begin
        mem_we = 1'b1;
        out_d  = '0;
        if (ptr_q == LAST_ADDR) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end

      IDLE: begin
        if (en) begin
          valid_d = 1'b1;
          if (in_range) begin
            rd_word = mem[address];
            // Same-address write: READ_MODE picks old word or incoming data.
            if (S) begin
              mem_we    = 1'b1;
              mem_waddr = address;
              mem_wdata = In;
              out_d     = (READ_MODE == WRITE_FIRST) ? In : rd_word;
            end else begin
              out_d = rd_word;
            end
          end else begin
            err_d = 1'b1;
            out_d = '0;
          end
        end
      end

      default: begin
        state_d = CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      if (mem_we) begin
        mem[mem_waddr] <= mem_wdata;
      end
    end
  end

  assign Out   = out_q;
  assign valid = valid_q;
  assign err   = err_q;
  assign busy  = (state_q == CLEAR);

endmodule
